// File: rtl/if_fetch_stage_pkg.sv
// Shared pipeline definitions for the fetch stage and the IF/ID register.
//   fetch_state_e : fetch handshake FSM states (request, wait, hold)
//   NOP_INSTR     : bubble word placed in the IF/ID register on flush/reset
//   if_id_t       : IF/ID bundle {instr, pc, pcplus4, valid}
package if_fetch_stage_pkg;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,   // request driven, waiting for grant
        ST_WAIT = 2'd1,   // one request outstanding, waiting for data
        ST_HOLD = 2'd2    // word returned but decode not ready; word buffered
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pcplus4;
        logic        valid;
    } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// Pipeline register between two stages with flush > stall > load priority.
// Ports:
//   clk, rst      : clock, async active-high reset
//   load          : capture d this edge (ignored when stalled or flushed)
//   stall         : hold all contents
//   flush         : replace instr with the bubble word and clear valid;
//                   pc/pcplus4 are kept so the PC trail stays observable
//   d / q         : bundle in / registered bundle out
module if_id_reg
    import if_fetch_stage_pkg::*;
#(
    parameter logic [31:0] BUBBLE_INSTR = 32'h0000_0000,
    parameter logic [31:0] RESET_PC     = 32'h0000_0000
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   load,
    input  logic   stall,
    input  logic   flush,
    input  if_id_t d,
    output if_id_t q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q.instr   <= BUBBLE_INSTR;
            q.pc      <= RESET_PC;
            q.pcplus4 <= RESET_PC;
            q.valid   <= 1'b0;
        end else if (flush) begin
            q.instr <= BUBBLE_INSTR;
            q.valid <= 1'b0;
        end else if (load && !stall) begin
            q <= d;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage plus IF/ID register.
// Runs a single-outstanding request/response handshake with instruction
// memory for the address on PCF, buffers the returned word while decode is
// stalled or flushed, and pulses FetchEn (to the PC register enable) on the
// cycle a word is handed to the IF/ID register.
// Ports:
//   clk, rst               : clock, async active-high reset
//   PCF, PCPlus4F          : current fetch address and its +4
//   StallD, FlushD         : hazard-unit hold / bubble requests for IF/ID
//   ImemReq, ImemAddr      : memory request valid / address (= PCF)
//   ImemGnt                : memory accepted the request
//   ImemRValid, ImemRData  : returned instruction word
//   FetchEn                : handoff strobe, drives PC register enable
//   InstrD, PCD, PCPlus4D, ValidD : IF/ID register contents
//   ErrSpurious            : sticky, read data seen with nothing outstanding
module if_fetch_stage #(
    parameter logic [31:0] NOP_INSTR = if_fetch_stage_pkg::NOP_INSTR,
    parameter logic [31:0] RESET_PCD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PCF,
    input  logic [31:0] PCPlus4F,
    input  logic        StallD,
    input  logic        FlushD,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic        ImemGnt,
    input  logic        ImemRValid,
    input  logic [31:0] ImemRData,
    output logic        FetchEn,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD,
    output logic        ErrSpurious
);
    import if_fetch_stage_pkg::*;

    fetch_state_e state, state_next;
    if_id_t       fetched, hold_buf, id_d, id_q;
    logic         rsp, ready, handoff, err;

    // PCF is stable until handoff, so it can be paired with the returning word.
    assign fetched = '{instr: ImemRData, pc: PCF, pcplus4: PCPlus4F, valid: 1'b1};

    assign rsp     = (state == ST_WAIT) && ImemRValid;
    // A flush suppresses handoff too: the word must not be lost into a bubble.
    assign ready   = !StallD && !FlushD;
    assign handoff = !rst && ready && (rsp || (state == ST_HOLD));

    assign ImemReq  = !rst && (state == ST_REQ);
    assign ImemAddr = PCF;
    assign FetchEn  = handoff;

    always_comb begin
        state_next = state;
        case (state)
            ST_REQ:  if (ImemGnt)    state_next = ST_WAIT;
            ST_WAIT: if (ImemRValid) state_next = handoff ? ST_REQ : ST_HOLD;
            ST_HOLD: if (handoff)    state_next = ST_REQ;
            default:                 state_next = ST_REQ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_REQ;
            hold_buf <= '0;
            err      <= 1'b0;
        end else begin
            state <= state_next;
            if (rsp && !handoff)
                hold_buf <= fetched;
            // Data with nothing outstanding: ignored, but flagged until reset.
            if (ImemRValid && (state != ST_WAIT))
                err <= 1'b1;
        end
    end

    assign id_d = (state == ST_HOLD) ? hold_buf : fetched;

    if_id_reg #(
        .BUBBLE_INSTR (NOP_INSTR),
        .RESET_PC     (RESET_PCD)
    ) u_if_id (
        .clk   (clk),
        .rst   (rst),
        .load  (handoff),
        .stall (StallD),
        .flush (FlushD),
        .d     (id_d),
        .q     (id_q)
    );

    assign InstrD      = id_q.instr;
    assign PCD         = id_q.pc;
    assign PCPlus4D    = id_q.pcplus4;
    assign ValidD      = id_q.valid;
    assign ErrSpurious = err;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: a directed per-cycle vector table, an async
// reset sequence, and a randomized run against a transaction-level model.
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pcf;
    logic [31:0] pcplus4f;
    logic        stall = 1'b0, flush = 1'b0;
    logic        req;
    logic [31:0] addr;
    logic        gnt = 1'b0, rvalid = 1'b0;
    logic [31:0] rdata = 32'h0;
    logic        fetch_en;
    logic [31:0] instr_d, pc_d, pcplus4_d;
    logic        valid_d, err;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    if_fetch_stage dut (
        .clk(clk), .rst(rst), .PCF(pcf), .PCPlus4F(pcplus4f),
        .StallD(stall), .FlushD(flush),
        .ImemReq(req), .ImemAddr(addr), .ImemGnt(gnt),
        .ImemRValid(rvalid), .ImemRData(rdata),
        .FetchEn(fetch_en), .InstrD(instr_d), .PCD(pc_d),
        .PCPlus4D(pcplus4_d), .ValidD(valid_d), .ErrSpurious(err)
    );

    // PC register of the surrounding pipeline, enabled by FetchEn.
    always @(posedge clk or posedge rst) begin
        if (rst)           pcf <= 32'h3000;
        else if (fetch_en) pcf <= pcf + 32'd4;
    end
    assign pcplus4f = pcf + 32'd4;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    typedef struct {
        logic        gnt, rv;
        logic [31:0] rdata;
        logic        stall, flush;
        logic        e_req, e_fen;
        logic [31:0] e_addr, e_instr, e_pcd;
        logic        e_valid, e_err;
    } vec_t;

    vec_t vec[18];

    // Transaction-level model state for the random run.
    bit          m_open, m_wait, m_held, m_err, m_valid;
    logic [31:0] m_instr, m_pc, m_pc4;
    logic [31:0] h_instr, h_pc, h_pc4;
    bit          mem_pending;
    int          mem_lat;

    initial begin
        //           gnt rv  rdata          stl flu req fen addr          instr          pcd           v  err
        vec[0]  = '{1, 0, 32'h0,         0, 0, 1, 0, 32'h3000, 32'h0,        32'h0,    0, 0};
        vec[1]  = '{0, 1, 32'h8C010000,  0, 0, 0, 1, 32'h3000, 32'h8C010000, 32'h3000, 1, 0};
        vec[2]  = '{0, 0, 32'h0,         0, 0, 1, 0, 32'h3004, 32'h8C010000, 32'h3000, 1, 0};
        vec[3]  = '{0, 0, 32'h0,         0, 0, 1, 0, 32'h3004, 32'h8C010000, 32'h3000, 1, 0};
        vec[4]  = '{1, 0, 32'h0,         0, 0, 1, 0, 32'h3004, 32'h8C010000, 32'h3000, 1, 0};
        vec[5]  = '{0, 0, 32'h0,         0, 0, 0, 0, 32'h3004, 32'h8C010000, 32'h3000, 1, 0};
        vec[6]  = '{0, 1, 32'h00430820,  0, 0, 0, 1, 32'h3004, 32'h00430820, 32'h3004, 1, 0};
        vec[7]  = '{1, 0, 32'h0,         0, 0, 1, 0, 32'h3008, 32'h00430820, 32'h3004, 1, 0};
        vec[8]  = '{0, 1, 32'h24020005,  1, 0, 0, 0, 32'h3008, 32'h00430820, 32'h3004, 1, 0};
        vec[9]  = '{0, 0, 32'h0,         1, 0, 0, 0, 32'h3008, 32'h00430820, 32'h3004, 1, 0};
        vec[10] = '{0, 0, 32'h0,         0, 0, 0, 1, 32'h3008, 32'h24020005, 32'h3008, 1, 0};
        vec[11] = '{0, 0, 32'h0,         0, 1, 1, 0, 32'h300C, 32'h0,        32'h3008, 0, 0};
        vec[12] = '{1, 0, 32'h0,         0, 0, 1, 0, 32'h300C, 32'h0,        32'h3008, 0, 0};
        vec[13] = '{0, 1, 32'h8C220004,  0, 1, 0, 0, 32'h300C, 32'h0,        32'h3008, 0, 0};
        vec[14] = '{0, 0, 32'h0,         0, 0, 0, 1, 32'h300C, 32'h8C220004, 32'h300C, 1, 0};
        vec[15] = '{0, 1, 32'hDEADBEEF,  0, 0, 1, 0, 32'h3010, 32'h8C220004, 32'h300C, 1, 1};
        vec[16] = '{1, 0, 32'h0,         0, 0, 1, 0, 32'h3010, 32'h8C220004, 32'h300C, 1, 1};
        vec[17] = '{0, 1, 32'h00000013,  0, 0, 0, 1, 32'h3010, 32'h00000013, 32'h3010, 1, 1};

        // Reset state, with grant/data asserted to show they are ignored.
        gnt = 1'b1; rvalid = 1'b1; rdata = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req", req, 1'b0);
        check("rst_fen", fetch_en, 1'b0);
        check("rst_instr", instr_d, 32'h0);
        check("rst_pcd", pc_d, 32'h0);
        check("rst_pc4d", pcplus4_d, 32'h0);
        check("rst_valid", valid_d, 1'b0);
        check("rst_err", err, 1'b0);
        rst = 1'b0;

        // Directed vector table: one row per cycle.
        for (int i = 0; i < 18; i++) begin
            gnt = vec[i].gnt; rvalid = vec[i].rv; rdata = vec[i].rdata;
            stall = vec[i].stall; flush = vec[i].flush;
            @(negedge clk);
            check($sformatf("v%0d_req", i), req, vec[i].e_req);
            check($sformatf("v%0d_fen", i), fetch_en, vec[i].e_fen);
            check($sformatf("v%0d_addr", i), addr, vec[i].e_addr);
            @(posedge clk); #1;
            check($sformatf("v%0d_instr", i), instr_d, vec[i].e_instr);
            check($sformatf("v%0d_pcd", i), pc_d, vec[i].e_pcd);
            check($sformatf("v%0d_pc4d", i), pcplus4_d,
                  (vec[i].e_pcd == 32'h0) ? 32'h0 : vec[i].e_pcd + 32'd4);
            check($sformatf("v%0d_valid", i), valid_d, vec[i].e_valid);
            check($sformatf("v%0d_err", i), err, vec[i].e_err);
        end

        // Async reset while a request is outstanding.
        gnt = 1'b1; rvalid = 1'b0; stall = 1'b0; flush = 1'b0;
        @(posedge clk); #1;
        gnt = 1'b0;
        check("wait_req", req, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("arst_req", req, 1'b0);
        check("arst_fen", fetch_en, 1'b0);
        check("arst_instr", instr_d, 32'h0);
        check("arst_pcd", pc_d, 32'h0);
        check("arst_pc4d", pcplus4_d, 32'h0);
        check("arst_valid", valid_d, 1'b0);
        check("arst_err", err, 1'b0);
        @(negedge clk); #1;
        rst = 1'b0;
        #1;
        check("post_rst_req", req, 1'b1);
        check("post_rst_addr", addr, 32'h3000);
        // Late response for the aborted request lands in REQ.
        rvalid = 1'b1; rdata = 32'h1234_5678;
        @(posedge clk); #1;
        rvalid = 1'b0;
        check("late_err", err, 1'b1);
        check("late_instr", instr_d, 32'h0);
        check("late_valid", valid_d, 1'b0);

        // Randomized run against the model.
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_open = 1; m_wait = 0; m_held = 0; m_err = 0; m_valid = 0;
        m_instr = 32'h0; m_pc = 32'h0; m_pc4 = 32'h0;
        h_instr = 32'h0; h_pc = 32'h0; h_pc4 = 32'h0;
        mem_pending = 0; mem_lat = 0;
        for (int c = 0; c < 1500; c++) begin
            bit exp_fen, fire;
            logic [31:0] d_instr, d_pc, d_pc4;
            fire   = mem_pending && (mem_lat == 0);
            rvalid = fire;
            rdata  = $urandom;
            gnt    = 1'($urandom_range(0, 1));
            stall  = ($urandom_range(0, 3) == 0);
            flush  = ($urandom_range(0, 7) == 0);
            @(negedge clk);
            exp_fen = ((m_wait && rvalid) || m_held) && !stall && !flush;
            check("rnd_req", req, m_open);
            check("rnd_fen", fetch_en, exp_fen);
            if (m_open) check("rnd_addr", addr, pcf);

            // Word handed over this cycle: buffered one, or the one arriving now.
            if (m_held) begin d_instr = h_instr; d_pc = h_pc; d_pc4 = h_pc4; end
            else        begin d_instr = rdata;   d_pc = pcf;  d_pc4 = pcf + 32'd4; end

            if (rvalid && !m_wait) m_err = 1;
            if (exp_fen) begin
                m_held = 0; m_wait = 0; m_open = 1;
            end else if (m_wait && rvalid) begin
                m_wait = 0; m_held = 1;
                h_instr = rdata; h_pc = pcf; h_pc4 = pcf + 32'd4;
            end else if (m_open && gnt) begin
                m_open = 0; m_wait = 1;
            end
            if (flush) begin
                m_instr = 32'h0; m_valid = 0;
            end else if (exp_fen) begin
                m_instr = d_instr; m_pc = d_pc; m_pc4 = d_pc4; m_valid = 1;
            end

            // Memory side: latency of 1..3 cycles after grant.
            if (req && gnt) begin
                mem_pending = 1; mem_lat = $urandom_range(0, 2);
            end else if (mem_pending) begin
                if (fire) mem_pending = 0;
                else      mem_lat--;
            end

            @(posedge clk); #1;
            check("rnd_instr", instr_d, m_instr);
            check("rnd_pcd", pc_d, m_pc);
            check("rnd_pc4d", pcplus4_d, m_pc4);
            check("rnd_valid", valid_d, m_valid);
            check("rnd_err", err, m_err);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
